// File: rtl/pll_hdmi_cfg_seq.sv
// pll_hdmi_cfg_seq
// Replays a stored PLL preset (N, M, C0, K, BW, CP) into the PLL reconfig
// Avalon-MM port. It then triggers reconfiguration and supervises relock,
// with a lock timeout and a bounded number of full retries.
//
// Ports
//   refclk, rst            : clock, asynchronous active-high reset
//   tbl_we/idx/field/data  : preset table write port (ignored while busy)
//   cfg_req, cfg_sel       : request to apply a preset
//   busy, done, err        : sequence status (done is a pulse, err is sticky)
//   cur_sel                : last successfully applied preset
//   mgmt_*                 : Avalon-MM master toward the reconfig bridge
//   locked                 : PLL lock, asynchronous to refclk
module pll_hdmi_cfg_seq #(
    parameter int unsigned NUM_PRESETS  = 4,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned RETRIES      = 2,
    localparam int unsigned SEL_W       = $clog2(NUM_PRESETS)
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             tbl_we,
    input  logic [SEL_W-1:0] tbl_idx,
    input  logic [2:0]       tbl_field,
    input  logic [31:0]      tbl_data,
    input  logic             cfg_req,
    input  logic [SEL_W-1:0] cfg_sel,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [SEL_W-1:0] cur_sel,
    output logic [5:0]       mgmt_address,
    output logic             mgmt_write,
    output logic [31:0]      mgmt_writedata,
    input  logic             mgmt_waitrequest,
    input  logic             locked
);

    typedef enum logic [3:0] {
        S_IDLE, S_MODE, S_WR_N, S_WR_M, S_WR_C, S_WR_K, S_WR_BW, S_WR_CP,
        S_START, S_LOCK
    } state_t;

    state_t state_q, state_d;

    logic [31:0] tbl_q  [NUM_PRESETS][6];
    logic [5:0]  mask_q [NUM_PRESETS];

    logic             locked_s1_q, locked_sync_q;
    logic [16:0]      tmo_q, tmo_d;
    logic [4:0]       stab_q, stab_d;
    logic [1:0]       retry_q, retry_d;
    logic [SEL_W-1:0] act_sel_q, act_sel_d;
    logic             pend_v_q, pend_v_d;
    logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic             wr_q, wr_d;
    logic [5:0]       addr_q, addr_d;
    logic [31:0]      data_q, data_d;

    logic             tbl_wr_en;
    logic [5:0]       tbl_fbit;
    logic             req_v;
    logic [SEL_W-1:0] req_sel;
    logic [5:0]       req_mask;

    assign tbl_wr_en = tbl_we && (state_q == S_IDLE) && (tbl_field < 3'd6)
                       && (32'(tbl_idx) < NUM_PRESETS);
    assign tbl_fbit  = 6'b1 << tbl_field;

    // Table storage needs no reset; only the written-masks are cleared.
    always_ff @(posedge refclk) begin
        if (tbl_wr_en) tbl_q[tbl_idx][tbl_field] <= tbl_data;
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_PRESETS; i++) mask_q[i] <= '0;
            state_q       <= S_IDLE;
            locked_s1_q   <= 1'b0;
            locked_sync_q <= 1'b0;
            tmo_q         <= '0;
            stab_q        <= '0;
            retry_q       <= '0;
            act_sel_q     <= '0;
            pend_v_q      <= 1'b0;
            pend_sel_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            cur_sel_q     <= '0;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
        end else begin
            if (tbl_wr_en) mask_q[tbl_idx] <= mask_q[tbl_idx] | tbl_fbit;
            state_q       <= state_d;
            locked_s1_q   <= locked;
            locked_sync_q <= locked_s1_q;
            tmo_q         <= tmo_d;
            stab_q        <= stab_d;
            retry_q       <= retry_d;
            act_sel_q     <= act_sel_d;
            pend_v_q      <= pend_v_d;
            pend_sel_q    <= pend_sel_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            cur_sel_q     <= cur_sel_d;
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
        end
    end

    // A fresh request in IDLE overrides a pending one (last request wins).
    // The validity check merges a same-cycle table write into the mask.
    assign req_v    = cfg_req | pend_v_q;
    assign req_sel  = cfg_req ? cfg_sel : pend_sel_q;
    assign req_mask = ((32'(req_sel) < NUM_PRESETS) ? mask_q[req_sel] : 6'b0)
                      | ((tbl_wr_en && tbl_idx == req_sel) ? tbl_fbit : 6'b0);

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        stab_d     = stab_q;
        retry_d    = retry_q;
        act_sel_d  = act_sel_q;
        pend_v_d   = pend_v_q;
        pend_sel_d = pend_sel_q;
        done_d     = 1'b0;
        err_d      = err_q;
        cur_sel_d  = cur_sel_q;

        if (state_q != S_IDLE && cfg_req) begin
            pend_v_d   = 1'b1;
            pend_sel_d = cfg_sel;
        end

        case (state_q)
            S_IDLE: begin
                if (req_v) begin
                    pend_v_d = 1'b0;
                    if (&req_mask) begin
                        err_d     = 1'b0;
                        act_sel_d = req_sel;
                        retry_d   = '0;
                        state_d   = S_MODE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_MODE:  if (!mgmt_waitrequest) state_d = S_WR_N;
            S_WR_N:  if (!mgmt_waitrequest) state_d = S_WR_M;
            S_WR_M:  if (!mgmt_waitrequest) state_d = S_WR_C;
            S_WR_C:  if (!mgmt_waitrequest) state_d = S_WR_K;
            S_WR_K:  if (!mgmt_waitrequest) state_d = S_WR_BW;
            S_WR_BW: if (!mgmt_waitrequest) state_d = S_WR_CP;
            S_WR_CP: if (!mgmt_waitrequest) state_d = S_START;
            S_START: begin
                if (!mgmt_waitrequest) begin
                    state_d = S_LOCK;
                    tmo_d   = '0;
                    stab_d  = '0;
                end
            end
            S_LOCK: begin
                stab_d = locked_sync_q ? stab_q + 5'd1 : 5'd0;
                if (locked_sync_q && stab_q == 5'(LOCK_STABLE - 1)) begin
                    done_d    = 1'b1;
                    cur_sel_d = act_sel_q;
                    state_d   = S_IDLE;
                end else if (tmo_q >= 17'(LOCK_TIMEOUT)) begin
                    if (retry_q < 2'(RETRIES)) begin
                        retry_d = retry_q + 2'd1;
                        state_d = S_MODE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 17'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state, so address/data are
    // presented in the same cycle the state is entered and stay put while
    // waitrequest holds the state.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        wr_d   = 1'b1;
        addr_d = addr_q;
        data_d = data_q;
        case (state_d)
            S_MODE:  begin addr_d = 6'd0; data_d = 32'd0; end
            S_WR_N:  begin addr_d = 6'd3; data_d = tbl_q[act_sel_d][0]; end
            S_WR_M:  begin addr_d = 6'd4; data_d = tbl_q[act_sel_d][1]; end
            S_WR_C:  begin
                addr_d = 6'd5;
                data_d = tbl_q[act_sel_d][2] & ~(32'h1F << 18);
            end
            S_WR_K:  begin addr_d = 6'd7; data_d = tbl_q[act_sel_d][3]; end
            S_WR_BW: begin addr_d = 6'd8; data_d = tbl_q[act_sel_d][4]; end
            S_WR_CP: begin addr_d = 6'd9; data_d = tbl_q[act_sel_d][5]; end
            S_START: begin addr_d = 6'd2; data_d = 32'd1; end
            default: wr_d = 1'b0;
        endcase
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign cur_sel        = cur_sel_q;
    assign mgmt_write     = wr_q;
    assign mgmt_address   = addr_q;
    assign mgmt_writedata = data_q;

endmodule

// File: tb/tb_pll_hdmi_cfg_seq.sv
// Scoreboard bench for pll_hdmi_cfg_seq: requests push the expected bus
// writes and outcome; a negedge monitor drives waitrequest and checks.
module tb_pll_hdmi_cfg_seq;
    localparam int NP = 4;
    localparam int SW = 2;
    localparam int LT = 100;
    localparam int LS = 16;
    localparam int RT = 2;

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          tbl_we = 1'b0;
    logic [SW-1:0] tbl_idx = '0;
    logic [2:0]    tbl_field = '0;
    logic [31:0]   tbl_data = '0;
    logic          cfg_req = 1'b0;
    logic [SW-1:0] cfg_sel = '0;
    logic          busy, done, err;
    logic [SW-1:0] cur_sel;
    logic [5:0]    mgmt_address;
    logic          mgmt_write;
    logic [31:0]   mgmt_writedata;
    logic          mgmt_waitrequest = 1'b0;
    logic          locked = 1'b1;

    pll_hdmi_cfg_seq #(
        .NUM_PRESETS(NP), .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS), .RETRIES(RT)
    ) dut (
        .refclk(refclk), .rst(rst), .tbl_we(tbl_we), .tbl_idx(tbl_idx),
        .tbl_field(tbl_field), .tbl_data(tbl_data), .cfg_req(cfg_req),
        .cfg_sel(cfg_sel), .busy(busy), .done(done), .err(err),
        .cur_sel(cur_sel), .mgmt_address(mgmt_address),
        .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata),
        .mgmt_waitrequest(mgmt_waitrequest), .locked(locked)
    );

    always #5 refclk = ~refclk;

    typedef struct { logic [5:0] a; logic [31:0] d; } wr_t;
    typedef struct { bit is_err; int sel; } out_t;

    wr_t  wq[$];
    out_t oq[$];
    logic [31:0] m_tbl [NP][6];
    logic [5:0]  m_mask [NP];
    int   m_cur = 0;
    bit   lock_ok = 1;
    int   wr_mode = 0;   // 0: no wait, 1: 3 cycles (500 on START), 2: random
    int   vecs = 0, errs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the full write list of one attempt for a slot.
    function automatic void push_seq(input int s);
        logic [5:0] ad [8];
        ad = '{6'd0, 6'd3, 6'd4, 6'd5, 6'd7, 6'd8, 6'd9, 6'd2};
        for (int k = 0; k < 8; k++) begin
            wr_t w;
            w.a = ad[k];
            if (k == 0) w.d = 32'd0;
            else if (k == 7) w.d = 32'd1;
            else w.d = m_tbl[s][k-1];
            if (k == 3) w.d[22:18] = 5'd0;
            wq.push_back(w);
        end
    endfunction

    function automatic bit expect_req(input int s);
        out_t o;
        o.sel = s;
        if (m_mask[s] != 6'h3F) begin
            o.is_err = 1;
            oq.push_back(o);
            return 0;
        end
        for (int a = 0; a < (lock_ok ? 1 : RT + 1); a++) push_seq(s);
        o.is_err = !lock_ok;
        oq.push_back(o);
        return 1;
    endfunction

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic tbl_wr(input int s, input int f, input logic [31:0] d, input bit upd);
        tbl_we = 1; tbl_idx = SW'(s); tbl_field = 3'(f); tbl_data = d;
        tick();
        tbl_we = 0;
        if (upd && f < 6) begin m_tbl[s][f] = d; m_mask[s][f] = 1'b1; end
    endtask

    task automatic post_req_chk(input bit v);
        if (v) chk("busy_rise", {31'd0, busy}, 32'd1);
        else begin
            chk("err_set", {31'd0, err}, 32'd1);
            chk("busy_stay_low", {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic req(input int s);
        bit v;
        v = expect_req(s);
        cfg_req = 1; cfg_sel = SW'(s);
        tick();
        cfg_req = 0;
        post_req_chk(v);
    endtask

    // Table write of one field and a request for the same slot in one cycle.
    task automatic req_wr(input int s, input int f, input logic [31:0] d);
        bit v;
        m_tbl[s][f] = d; m_mask[s][f] = 1'b1;
        v = expect_req(s);
        tbl_we = 1; tbl_idx = SW'(s); tbl_field = 3'(f); tbl_data = d;
        cfg_req = 1; cfg_sel = SW'(s);
        tick();
        tbl_we = 0; cfg_req = 0;
        post_req_chk(v);
    endtask

    task automatic load_slot(input int s, input logic [31:0] v [6]);
        for (int f = 0; f < 6; f++) tbl_wr(s, f, v[f], 1);
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while ((wq.size() != 0 || oq.size() != 0) && n < lim) begin
            @(negedge refclk);
            n++;
        end
        chk("drain_in_time", {31'd0, n < lim}, 32'd1);
        repeat (3) tick();
    endtask

    // Monitor: drives waitrequest, checks stability and every accepted write,
    // and checks done pulses and err rises against the outcome queue.
    bit          in_write = 0;
    int          wait_left = 0;
    logic [5:0]  held_a;
    logic [31:0] held_d;
    logic        err_prev = 0;

    always @(negedge refclk) begin
        if (rst) begin
            in_write = 0;
            mgmt_waitrequest = 0;
        end else begin
            if (mgmt_write) begin
                if (!in_write) begin
                    in_write = 1;
                    held_a = mgmt_address;
                    held_d = mgmt_writedata;
                    case (wr_mode)
                        1: wait_left = (mgmt_address == 6'd2) ? 500 : 3;
                        2: wait_left = $urandom_range(0, 2);
                        default: wait_left = 0;
                    endcase
                end else begin
                    chk("addr_stable", {26'd0, mgmt_address}, {26'd0, held_a});
                    chk("data_stable", mgmt_writedata, held_d);
                    if (wait_left > 0) wait_left--;
                end
                mgmt_waitrequest = (wait_left != 0);
                if (!mgmt_waitrequest) begin
                    in_write = 0;
                    if (wq.size() == 0) begin
                        chk("unexpected_write_addr", {26'd0, mgmt_address}, 32'hFFFFFFFF);
                    end else begin
                        wr_t w;
                        w = wq.pop_front();
                        chk("wr_addr", {26'd0, mgmt_address}, {26'd0, w.a});
                        chk("wr_data", mgmt_writedata, w.d);
                    end
                end
            end else begin
                in_write = 0;
                mgmt_waitrequest = 0;
            end
            if (done) begin
                if (oq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    out_t o;
                    o = oq.pop_front();
                    chk("done_kind", {31'd0, o.is_err}, 32'd0);
                    chk("cur_sel_set", {30'd0, cur_sel}, 32'(o.sel));
                    chk("busy_fall", {31'd0, busy}, 32'd0);
                    m_cur = o.sel;
                end
            end
            if (err && !err_prev) begin
                if (oq.size() == 0) chk("unexpected_err", 32'd1, 32'd0);
                else begin
                    out_t o;
                    o = oq.pop_front();
                    chk("err_kind", {31'd0, o.is_err}, 32'd1);
                    chk("cur_sel_keep", {30'd0, cur_sel}, 32'(m_cur));
                end
            end
        end
        err_prev = err;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v [6];
        int n;
        for (int i = 0; i < NP; i++) m_mask[i] = '0;

        repeat (3) @(posedge refclk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_cur_sel", {30'd0, cur_sel}, 32'd0);
        chk("rst_write", {31'd0, mgmt_write}, 32'd0);
        chk("rst_addr", {26'd0, mgmt_address}, 32'd0);
        chk("rst_data", mgmt_writedata, 32'd0);
        rst = 0;
        tick();

        // Directed slot 1, zero waitrequest.
        v = '{32'h00010000, 32'h00000404, 32'h00010201, 32'hE8F5C239, 32'd6, 32'd1};
        load_slot(1, v);
        req(1);
        drain(200);
        chk("idle_after_done", {31'd0, busy}, 32'd0);

        // Same with waitrequest stretching; table writes while busy ignored.
        wr_mode = 1;
        req(1);
        repeat (2) tick();
        tbl_wr(1, 0, 32'hDEADBEEF, 0);
        tbl_wr(1, 3, 32'h12345678, 0);
        drain(2000);
        wr_mode = 0;

        // Table write in IDLE is accepted.
        tbl_wr(1, 0, 32'h00020000, 1);
        req(1);
        drain(200);

        // Lock never comes: three attempts, then err.
        lock_ok = 0;
        locked = 0;
        req(1);
        drain(3000);
        lock_ok = 1;
        locked = 1;

        // Valid request clears err.
        req(1);
        chk("err_cleared", {31'd0, err}, 32'd0);
        drain(200);

        // Partially written slot 2 is rejected without bus traffic.
        for (int f = 0; f < 5; f++) tbl_wr(2, f, $urandom, 1);
        req(2);
        repeat (5) tick();
        chk("no_write_invalid", {31'd0, mgmt_write}, 32'd0);
        req(1);
        chk("err_cleared2", {31'd0, err}, 32'd0);
        drain(200);

        // Requests during busy: last one wins, exactly one further sequence.
        tbl_wr(2, 5, $urandom, 1);
        for (int f = 0; f < 6; f++) tbl_wr(3, f, $urandom, 1);
        req(2);
        repeat (3) tick();
        cfg_req = 1; cfg_sel = 2'd0; tick(); cfg_req = 0;
        repeat (2) tick();
        push_seq(3);
        oq.push_back('{0, 3});
        cfg_req = 1; cfg_sel = 2'd3; tick(); cfg_req = 0;
        drain(400);

        // Randomized presets, random waitrequest, last field written with request.
        wr_mode = 2;
        for (int it = 0; it < 6; it++) begin
            int s;
            s = $urandom_range(0, NP - 1);
            for (int f = 0; f < 5; f++) tbl_wr(s, f, $urandom, 1);
            req_wr(s, 5, $urandom);
            drain(400);
        end
        wr_mode = 0;

        // Asynchronous reset during the K write.
        req(1);
        n = 0;
        while (!(mgmt_write && mgmt_address == 6'd7) && n < 200) begin
            @(negedge refclk);
            n++;
        end
        chk("reached_wr_k", {31'd0, n < 200}, 32'd1);
        #2 rst = 1;
        #1;
        chk("arst_write", {31'd0, mgmt_write}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_addr", {26'd0, mgmt_address}, 32'd0);
        chk("arst_data", mgmt_writedata, 32'd0);
        chk("arst_cur_sel", {30'd0, cur_sel}, 32'd0);
        chk("arst_err", {31'd0, err}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        wq.delete();
        oq.delete();
        for (int i = 0; i < NP; i++) m_mask[i] = '0;
        m_cur = 0;
        repeat (2) tick();
        rst = 0;
        tick();

        // Masks were cleared by reset: slot 1 is invalid until reloaded.
        req(1);
        repeat (2) tick();
        load_slot(1, v);
        req(1);
        drain(200);

        repeat (50) tick();
        chk("writes_left", wq.size(), 32'd0);
        chk("outcomes_left", oq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/pll_hdmi_cfg_seq.md
# pll_hdmi_cfg_seq

Reconfiguration sequencer for the reconfigurable HDMI video PLL. It holds a run-time loadable table of `NUM_PRESETS` PLL settings: N, M, C0, fractional K, bandwidth and charge pump. On request, it replays the selected preset into the PLL reconfiguration Avalon-MM port, triggers the reconfiguration and supervises relock, with timeout and retry. It sits between the HPS-side video-mode logic and the `reconfig_to_pll`/`reconfig_from_pll` reconfig bridge, so the HDMI pixel clock can be switched without rebuilding the bitstream.

## Interface
- `NUM_PRESETS`, 4: number of preset slots (≥2); `SEL_W = $clog2(NUM_PRESETS)`.
- `LOCK_TIMEOUT`, 65535: refclk cycles allowed for lock after start completes.
- `LOCK_STABLE`, 16: consecutive cycles `locked` must be high to count as locked.
- `RETRIES`, 2: extra full attempts after a lock timeout.

- `refclk`  in  1  block clock (50 MHz reference domain).
- `rst`  in  1  reset; asynchronous, active-high.
- `tbl_we`  in  1  table write strobe.
- `tbl_idx`  in  SEL_W  preset slot.
- `tbl_field`  in  3  field code: 0=N, 1=M, 2=C0, 3=K, 4=BW, 5=CP. Codes 6–7 are ignored.
- `tbl_data`  in  32  field value, in reconfig-register encoding.
- `cfg_req`  in  1  single-cycle request to apply preset `cfg_sel`.
- `cfg_sel`  in  SEL_W  preset to apply.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse on successful lock.
- `err`  out  1  sticky failure flag.
- `cur_sel`  out  SEL_W  last successfully applied preset.
- `mgmt_address`  out  6  reconfig register address.
- `mgmt_write`  out  1  Avalon write.
- `mgmt_writedata`  out  32  Avalon write data.
- `mgmt_waitrequest`  in  1  Avalon waitrequest.
- `locked`  in  1  PLL lock; asynchronous to `refclk` and double-synchronised internally.

## Operation
- **Table:** `NUM_PRESETS`×6 words of 32 bits, plus a 6-bit written-mask per slot.
  - A slot is valid when its mask is all ones.
  - `tbl_we` is ignored while `busy`=1.
  - Reset clears the masks only; data contents are don't-care.
- **Request acceptance:** `cfg_req` is accepted in IDLE.
  - While `busy`, a `cfg_req` is latched into a one-deep pending register; last request wins.
  - A pending request is taken on return to IDLE.
  - Accepting any request clears `err`.
  - If the requested slot is invalid, `err` sets in the acceptance cycle, there is no bus traffic, and the block stays in IDLE.
- **States:** IDLE → MODE → WR_N → WR_M → WR_C → WR_K → WR_BW → WR_CP → START → LOCK → IDLE.
- **Writes issued, in order:**
  - MODE writes address 0 with data 0 (waitrequest mode).
  - WR_N…WR_CP write addresses 3, 4, 5, 7, 8, 9 with the slot's N, M, C0, K, BW, CP words. For C0, bits [22:18] are forced to 0 (counter select).
  - START writes address 2 with data 1.
- **Bus handshake:** `mgmt_write`, address and data are held stable until a cycle with `mgmt_waitrequest`=0; the state advances on that edge. `mgmt_write` is low in IDLE and LOCK.
- **LOCK state:** counts up to `LOCK_TIMEOUT`. Success is `locked_sync` high for `LOCK_STABLE` consecutive cycles, which gives a `done` pulse, sets `cur_sel`, and returns to IDLE.
  - On timeout with retries left, the sequence restarts at MODE.
  - With no retries left, `err` sets and the block returns to IDLE; `cur_sel` is unchanged.
- **Arithmetic:** the timeout counter is 17 bits and saturates, the stable counter is 5 bits, and the retry counter is 2 bits. No wrap is permitted.

## Timing
- **Reset values:** `busy`=0, `done`=0, `err`=0, `cur_sel`=0, `mgmt_write`=0, `mgmt_address`=0, `mgmt_writedata`=0. Pending request cleared; state IDLE.
- **Reset mid-sequence:** `mgmt_write` drops immediately (asynchronous reset). The PLL is left as-is; software re-requests.
- **Latency, zero waitrequest:** `busy` rises the cycle after `cfg_req`. The 8 writes take 8 consecutive cycles. The lock phase takes ≥`LOCK_STABLE`+2 cycles, including the synchroniser.
- **Outputs:** `done` and the `busy` fall coincide. All outputs are registered.
- **Simultaneous `cfg_req` and `tbl_we` in IDLE:** the table write lands first, so the request sees the updated mask.

## Test plan
- Load slot 1 with N=0x00010000, M=0x00000404, C0=0x00010201, K=0xE8F5C239, BW=6, CP=1; pulse `cfg_req` with sel=1 and `mgmt_waitrequest`=0; hold `locked` high → writes to addresses 0, 3, 4, 5, 7, 8, 9, 2 with exactly those data, then `done` pulse, `cur_sel`=1, `busy` low.
- Same sequence with `mgmt_waitrequest` high for 3 cycles on each write, and 500 cycles on START → address and data held stable, no write skipped or duplicated.
- `locked` held low, `LOCK_TIMEOUT`=100 → 3 full write sequences, then `err`=1, no `done`, `cur_sel` unchanged.
- Request slot 2 after writing only 5 of its fields → `err`=1 next cycle, `mgmt_write` never asserted; a later valid request clears `err`.
- `cfg_req` sel=2 then sel=3 during busy → the current sequence completes, then exactly one further sequence for slot 3.
- `rst` asserted during WR_K with `mgmt_write`=1 → all outputs return to reset values asynchronously; `tbl_we` is ignored during busy and accepted in IDLE.
